// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Loadable WIDTH-bit down counter with a one-shot countdown FSM.
// The decrement is a ripple chain of half-subtractor stages, the subtract
// counterpart of the half-adder up counter. The counter free-runs and wraps
// on En. A Load arms a countdown: Busy stays high while it runs, and a
// single-cycle Done pulse marks the enabled edge that takes Count from 1 to 0.
//
// Ports
//   Clk      in   clock, rising-edge active
//   Rst      in   asynchronous active-low reset; release is synchronous to Clk
//   En       in   count enable, decrement by one per enabled edge
//   Load     in   synchronous load strobe, has priority over En
//   LoadVal  in   WIDTH-bit value captured on Load
//   Count    out  registered counter value
//   Borrow   out  combinational borrow-out of the top subtractor stage
//   Busy     out  registered, high while the FSM is in RUN
//   Done     out  registered, one-cycle pulse on entry to EXPIRED
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Count,
    output logic             Borrow,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] COUNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    state_t           state_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH:0]   b_s;   // borrow chain, b_s[0] is the chain input
    logic [WIDTH-1:0] d_s;   // decremented value

    // Ripple half-subtractor chain; Load suppresses the chain input so a
    // loading cycle never reports a borrow.
    always_comb begin
        b_s    = {(WIDTH+1){1'b0}};
        d_s    = COUNT_ZERO;
        b_s[0] = En & ~Load;
        for (int i = 0; i < WIDTH; i++) begin
            d_s[i]   = count_r[i] ^ b_s[i];
            b_s[i+1] = ~count_r[i] & b_s[i];
        end
    end

    // Counter register and countdown FSM with registered Busy/Done.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count_r <= COUNT_ZERO;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (Load) begin
                count_r <= LoadVal;
                if (LoadVal != COUNT_ZERO) begin
                    state_r <= ST_RUN;
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                end else begin
                    // A zero load expires immediately.
                    state_r <= ST_EXPIRED;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
            end else begin
                if (En) begin
                    count_r <= d_s;
                end else begin
                    count_r <= count_r;
                end
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                    ST_RUN: begin
                        // Terminal edge: this decrement takes Count to zero.
                        if (En && (count_r == COUNT_ONE)) begin
                            state_r <= ST_EXPIRED;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                    ST_EXPIRED: begin
                        state_r <= ST_EXPIRED;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                    default: begin
                        // Unused encoding recovers to IDLE.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Count  = count_r;
    assign Borrow = b_s[WIDTH];
    assign Busy   = busy_r;
    assign Done   = done_r;

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
//
// Self-checking bench for down_counter (WIDTH=3). Directed sequences cover
// reset, countdown, gapped enable, load priority, zero load and async reset;
// a randomized phase follows. Expected values come from a behavioural model
// that tracks the count as an integer modulo 2^W and a countdown-active flag.
// -----------------------------------------------------------------------------
module tb_down_counter;

    localparam int W   = 3;
    localparam int MOD = 1 << W;

    logic         Clk;
    logic         Rst;
    logic         En;
    logic         Load;
    logic [W-1:0] LoadVal;
    logic [W-1:0] Count;
    logic         Borrow;
    logic         Busy;
    logic         Done;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int m_count  = 0;
    bit m_active = 1'b0;
    bit m_done   = 1'b0;

    down_counter #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .En      (En),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Count   (Count),
        .Borrow  (Borrow),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_active = 1'b0;
        m_done   = 1'b0;
    endtask

    // One clock cycle: drive inputs, check Borrow, clock, check registers.
    task automatic step(input bit en, input bit ld, input int lv);
        En      = en;
        Load    = ld;
        LoadVal = lv[W-1:0];
        #1;
        check("borrow", int'(Borrow), int'(en && !ld && (m_count == 0)));
        @(posedge Clk);
        m_done = 1'b0;
        if (ld) begin
            m_count  = lv % MOD;
            m_active = (m_count != 0);
            m_done   = (m_count == 0);
        end else if (en) begin
            if (m_active && m_count == 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
            m_count = (m_count + MOD - 1) % MOD;
        end
        #1;
        check("count", int'(Count), m_count);
        check("busy",  int'(Busy),  int'(m_active));
        check("done",  int'(Done),  int'(m_done));
    endtask

    // Pull reset low between edges, confirm outputs clear without a clock,
    // then release away from the edge.
    task automatic async_reset();
        #3;
        Rst = 1'b0;
        #1;
        model_reset();
        check("arst_count", int'(Count), 0);
        check("arst_busy",  int'(Busy),  0);
        check("arst_done",  int'(Done),  0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        Rst     = 1'b0;
        En      = 1'b1;
        Load    = 1'b0;
        LoadVal = '0;
        model_reset();

        // Reset held for two cycles with En high.
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            check("rst_count", int'(Count), 0);
            check("rst_busy",  int'(Busy),  0);
            check("rst_done",  int'(Done),  0);
        end
        Rst = 1'b1;

        // Free run after release: 0 (borrow), 7,6,...,0,7.
        check("post_rel_count", int'(Count), 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);

        // Countdown of 3.
        step(1'b0, 1'b1, 3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);

        // Gapped enable countdown of 5.
        step(1'b0, 1'b1, 5);
        for (int i = 0; i < 12; i++) step(i % 2 == 0, 1'b0, 0);

        // Load priority on the terminal edge.
        step(1'b0, 1'b1, 2);
        step(1'b1, 1'b0, 0);
        check("prio_pre_count", int'(Count), 1);
        step(1'b1, 1'b1, 4);
        check("prio_count", int'(Count), 4);
        check("prio_done",  int'(Done),  0);
        check("prio_busy",  int'(Busy),  1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);

        // Zero load then wrap.
        step(1'b0, 1'b1, 0);
        check("zero_done", int'(Done), 1);
        check("zero_busy", int'(Busy), 0);
        step(1'b1, 1'b0, 0);
        check("zero_wrap", int'(Count), MOD - 1);
        step(1'b1, 1'b0, 0);
        // Back-to-back zero loads give consecutive Done.
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);

        // Async reset mid-countdown, then IDLE behaviour after release.
        step(1'b0, 1'b1, 6);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        async_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 0);

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            bit en_r;
            bit ld_r;
            int lv_r;
            en_r = ($urandom_range(3, 0) != 0);
            ld_r = ($urandom_range(7, 0) == 0);
            lv_r = $urandom_range(MOD - 1, 0);
            if ($urandom_range(99, 0) == 0) async_reset();
            else step(en_r, ld_r, lv_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
